// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: widths and entry type shared by the fetch queue and its interface
package fetch_queue_pkg;
  localparam int MEMI_SIZE_LOG = 4;
  localparam int INST_LEN = 8;
  localparam int FQ_DEPTH = 4;
  localparam int FQ_DEPTH_LOG = 2;
  typedef logic [MEMI_SIZE_LOG-1:0] pc_t;
  typedef logic [INST_LEN-1:0] inst_t;
  typedef logic [FQ_DEPTH_LOG-1:0] ptr_t;
  typedef logic [FQ_DEPTH_LOG:0] cnt_t;
  typedef struct packed {
    pc_t pc;
    inst_t inst;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: memi fetch port, commit redirect and dispatch handshake of the fetch queue
interface fetch_queue_if;
  import fetch_queue_pkg::*;
  pc_t memi_req_addr;
  inst_t memi_resp_data;
  logic redirect_valid;
  pc_t redirect_pc;
  logic deq_valid;
  logic deq_ready;
  pc_t deq_pc;
  inst_t deq_inst;
  cnt_t fq_count;
  logic fq_full;
  modport master (
    input memi_req_addr, deq_valid, deq_pc, deq_inst, fq_count, fq_full,
    output memi_resp_data, redirect_valid, redirect_pc, deq_ready
  );
  modport slave (
    output memi_req_addr, deq_valid, deq_pc, deq_inst, fq_count, fq_full,
    input memi_resp_data, redirect_valid, redirect_pc, deq_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC and buffers {pc, inst} pairs between memi and dispatch
module fetch_queue
  import fetch_queue_pkg::*;
(
  input logic clk,
  input logic rst,
  fetch_queue_if.slave fq
);
  pc_t fetch_pc;
  ptr_t head, tail;
  cnt_t count;
  fq_entry_t ent [FQ_DEPTH];
  logic enq, deq;
  assign fq.memi_req_addr = fetch_pc;
  assign fq.deq_valid = count != '0;
  assign fq.fq_full = count == cnt_t'(FQ_DEPTH);
  assign fq.fq_count = count;
  assign fq.deq_pc = ent[head].pc;
  assign fq.deq_inst = ent[head].inst;
  assign enq = !fq.redirect_valid && !fq.fq_full;
  assign deq = !fq.redirect_valid && fq.deq_valid && fq.deq_ready;
  // a squash drops the head even if dispatch accepts it, since dispatch is squashed too
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) ent[i] <= '0;
    end else if (fq.redirect_valid) begin
      fetch_pc <= fq.redirect_pc;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        ent[tail] <= '{pc: fetch_pc, inst: fq.memi_resp_data};
        tail <= tail + 1'b1;
        fetch_pc <= fetch_pc + 1'b1;
      end
      if (deq) head <= head + 1'b1;
      count <= count + cnt_t'(enq) - cnt_t'(deq);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a queue-based model of the fetch queue
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  logic clk = 0;
  logic rst = 1;
  logic chk_en = 0;
  int errors = 0;
  int checks = 0;
  logic [INST_LEN-1:0] mem [16];
  fq_entry_t mq[$];
  int pops[$];
  int mpc = 0;
  fetch_queue_if fq();
  fetch_queue dut (.clk(clk), .rst(rst), .fq(fq.slave));
  assign fq.memi_resp_data = mem[fq.memi_req_addr];
  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    bit was_full;
    fq_entry_t e;
    if (rst) begin
      mq.delete();
      mpc = 0;
    end else if (fq.redirect_valid) begin
      mq.delete();
      mpc = int'(fq.redirect_pc);
    end else begin
      was_full = mq.size() == FQ_DEPTH;
      if (mq.size() != 0 && fq.deq_ready) begin
        e = mq.pop_front();
        pops.push_back(int'(e.pc));
      end
      if (!was_full) begin
        mq.push_back('{pc: pc_t'(mpc), inst: mem[mpc]});
        mpc = (mpc + 1) % 16;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_count", 32'(fq.fq_count), mq.size());
      check("model_valid", 32'(fq.deq_valid), 32'(mq.size() != 0));
      check("model_full", 32'(fq.fq_full), 32'(mq.size() == FQ_DEPTH));
      check("model_addr", 32'(fq.memi_req_addr), mpc);
      if (mq.size() != 0) begin
        check("model_deq_pc", 32'(fq.deq_pc), 32'(mq[0].pc));
        check("model_deq_inst", 32'(fq.deq_inst), 32'(mq[0].inst));
      end
    end
  end

  initial begin
    fq.redirect_valid = 0;
    fq.redirect_pc = '0;
    fq.deq_ready = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
    cyc(2);
    chk_en = 1;
    rst = 0;
    check("rst_count", 32'(fq.fq_count), 0);
    check("rst_valid", 32'(fq.deq_valid), 0);
    check("rst_full", 32'(fq.fq_full), 0);
    check("rst_addr", 32'(fq.memi_req_addr), 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      check("fill_count", 32'(fq.fq_count), k < 4 ? k : 4);
      check("fill_full", 32'(fq.fq_full), 32'(k >= 4));
    end
    check("fill_addr_hold", 32'(fq.memi_req_addr), 4);
    check("fill_head_pc", 32'(fq.deq_pc), 0);
    check("fill_head_inst", 32'(fq.deq_inst), 32'h10);
    pops.delete();
    fq.deq_ready = 1;
    cyc(1);
    check("drain_count1", 32'(fq.fq_count), 3);
    cyc(1);
    check("drain_count2", 32'(fq.fq_count), 3);
    cyc(3);
    check("drain_pops", pops.size(), 5);
    for (int i = 0; i < 5 && i < pops.size(); i++) check("drain_order", pops[i], i);
    rst = 1;
    fq.deq_ready = 0;
    cyc(1);
    rst = 0;
    cyc(2);
    check("redir_pre_count", 32'(fq.fq_count), 2);
    fq.redirect_valid = 1;
    fq.redirect_pc = 4'd9;
    fq.deq_ready = 1;
    cyc(1);
    fq.redirect_valid = 0;
    fq.deq_ready = 0;
    check("redir_count", 32'(fq.fq_count), 0);
    check("redir_valid", 32'(fq.deq_valid), 0);
    check("redir_addr", 32'(fq.memi_req_addr), 9);
    cyc(1);
    check("redir_valid2", 32'(fq.deq_valid), 1);
    check("redir_pc", 32'(fq.deq_pc), 9);
    check("redir_inst", 32'(fq.deq_inst), 32'h19);
    rst = 1;
    fq.deq_ready = 1;
    cyc(1);
    rst = 0;
    check("empty_valid0", 32'(fq.deq_valid), 0);
    pops.delete();
    cyc(1);
    check("empty_valid1", 32'(fq.deq_valid), 1);
    check("empty_pc0", 32'(fq.deq_pc), 0);
    cyc(1);
    check("empty_pc1", 32'(fq.deq_pc), 1);
    check("empty_pops", pops.size(), 1);
    fq.redirect_valid = 1;
    fq.redirect_pc = 4'd15;
    cyc(1);
    fq.redirect_valid = 0;
    pops.delete();
    cyc(4);
    check("wrap_pops", pops.size(), 3);
    if (pops.size() == 3) begin
      check("wrap_pop0", pops[0], 15);
      check("wrap_pop1", pops[1], 0);
      check("wrap_pop2", pops[2], 1);
    end
    fq.deq_ready = 0;
    rst = 1;
    cyc(1);
    rst = 0;
    cyc(3);
    check("rstwin_pre", 32'(fq.fq_count), 3);
    rst = 1;
    fq.redirect_valid = 1;
    fq.redirect_pc = 4'd5;
    cyc(1);
    rst = 0;
    fq.redirect_valid = 0;
    check("rstwin_addr", 32'(fq.memi_req_addr), 0);
    check("rstwin_count", 32'(fq.fq_count), 0);
    check("rstwin_valid", 32'(fq.deq_valid), 0);
    for (int b = 0; b < 6; b++) begin
      for (int c = 0; c < 500; c++) begin
        fq.deq_ready = ($urandom % 6) < b;
        fq.redirect_valid = ($urandom % 25) == 0;
        fq.redirect_pc = pc_t'($urandom);
        rst = ($urandom % 150) == 0;
        if (($urandom % 8) == 0) mem[$urandom % 16] = 8'($urandom);
        cyc(1);
      end
    end
    rst = 0;
    fq.redirect_valid = 0;
    cyc(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
